// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one 32x8 synchronous data memory between two
// requesters. Port A is the datapath and port B is the loader/debug path.
// Requests are served round-robin. Each access is issued as a single-cycle
// mem_read or mem_write strobe, and read data comes back with a valid pulse.
//
// Ports
//   clock, clear            system clock; synchronous active-high reset
//   req_x/we_x/addr_x/wdata_x  requester x in {a,b}: request, write enable,
//                              address, write data (held until gnt_x)
//   gnt_x                   one-cycle pulse when x's access is issued
//   rvalid_x/rdata_x        read-data valid pulse; data held until next read
//   mem_read/mem_write      memory strobes (never both high)
//   mem_addr/mem_wdata      memory address / write data
//   mem_rdata               registered memory output (1 cycle after mem_read)
//   busy                    high whenever the FSM is not IDLE
module data_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  state_e                state_q, state_d;
  port_e                 rr_q, rr_d;
  port_e                 win_q, win_d;
  port_e                 pick_c;
  logic                  gnt_a_q, gnt_a_d;
  logic                  gnt_b_q, gnt_b_d;
  logic                  rvalid_a_q, rvalid_a_d;
  logic                  rvalid_b_q, rvalid_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;

  // Winner when sampling in IDLE: the sole requester, else the rr_ptr side.
  always_comb begin
    pick_c = PORT_B;
    if (req_a && (!req_b || (rr_q == PORT_A))) begin
      pick_c = PORT_A;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    rvalid_a_d  = 1'b0;
    rvalid_b_d  = 1'b0;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          state_d = S_ISSUE;
          win_d   = pick_c;
          // The loser of this round gets priority next time.
          rr_d    = (pick_c == PORT_A) ? PORT_B : PORT_A;
          if (pick_c == PORT_A) begin
            gnt_a_d     = 1'b1;
            mem_addr_d  = addr_a;
            mem_write_d = we_a;
            mem_read_d  = !we_a;
            if (we_a) mem_wdata_d = wdata_a;
          end else begin
            gnt_b_d     = 1'b1;
            mem_addr_d  = addr_b;
            mem_write_d = we_b;
            mem_read_d  = !we_b;
            if (we_b) mem_wdata_d = wdata_b;
          end
        end
      end
      S_ISSUE: begin
        // A write is committed at the end of this cycle; a read needs a capture cycle.
        state_d = mem_write_q ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        if (win_q == PORT_A) begin
          rdata_a_d  = mem_rdata;
          rvalid_a_d = 1'b1;
        end else begin
          rdata_b_d  = mem_rdata;
          rvalid_b_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      rr_q        <= PORT_A;
      win_q       <= PORT_A;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter: a behavioural 32x8 memory, a negedge
// scoreboard monitor and a linear directed and random stimulus sequence.
module tb_data_memory_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          clock = 1'b0;
  logic          clear;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          mem_read, mem_write, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem    [32] = '{default: '0};
  logic [DW-1:0] golden [32] = '{default: '0};
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  logic [DW-1:0] hold_a = '0;
  logic [DW-1:0] hold_b = '0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .clear     (clear),
    .req_a     (req_a),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .gnt_a     (gnt_a),
    .rvalid_a  (rvalid_a),
    .rdata_a   (rdata_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .gnt_b     (gnt_b),
    .rvalid_b  (rvalid_b),
    .rdata_b   (rdata_b),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Synchronous memory: write on strobe, registered read data.
  always @(posedge clock) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata     <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: expected read data is pushed at grant time from the golden
  // image and popped on rvalid. A visible clear means reset already happened.
  always @(negedge clock) begin
    if (clear) begin
      chk("rst_ctrl", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_read, mem_write, busy}), 32'd0);
      chk("rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
      qa.delete();
      qb.delete();
      hold_a = '0;
      hold_b = '0;
    end else begin
      if (rvalid_a) begin
        if (qa.size() == 0) chk("rvalid_a_unexpected", 32'(rvalid_a), 32'd0);
        else begin
          hold_a = qa.pop_front();
          chk("rdata_a", 32'(rdata_a), 32'(hold_a));
        end
      end else chk("rdata_a_hold", 32'(rdata_a), 32'(hold_a));
      if (rvalid_b) begin
        if (qb.size() == 0) chk("rvalid_b_unexpected", 32'(rvalid_b), 32'd0);
        else begin
          hold_b = qb.pop_front();
          chk("rdata_b", 32'(rdata_b), 32'(hold_b));
        end
      end else chk("rdata_b_hold", 32'(rdata_b), 32'(hold_b));
      chk("strobe_excl", 32'(mem_read & mem_write), 32'd0);
      chk("strobe_vs_gnt", 32'(mem_read | mem_write), 32'(gnt_a | gnt_b));
      if (gnt_a) begin
        chk("gnt_excl", 32'(gnt_b), 32'd0);
        chk("a_addr", 32'(mem_addr), 32'(addr_a));
        if (we_a) begin
          chk("a_wr_strobe", 32'({mem_write, mem_read}), 32'd2);
          chk("a_wr_data", 32'(mem_wdata), 32'(wdata_a));
          golden[addr_a] = wdata_a;
        end else begin
          chk("a_rd_strobe", 32'({mem_write, mem_read}), 32'd1);
          qa.push_back(golden[addr_a]);
        end
      end
      if (gnt_b) begin
        chk("b_addr", 32'(mem_addr), 32'(addr_b));
        if (we_b) begin
          chk("b_wr_strobe", 32'({mem_write, mem_read}), 32'd2);
          chk("b_wr_data", 32'(mem_wdata), 32'(wdata_b));
          golden[addr_b] = wdata_b;
        end else begin
          chk("b_rd_strobe", 32'({mem_write, mem_read}), 32'd1);
          qb.push_back(golden[addr_b]);
        end
      end
    end
  end

  // Advance one cycle; inputs are driven just after the falling edge.
  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

    // Reset held for two cycles with both requests pending.
    req_a = 1'b1; addr_a = AW'(0);
    req_b = 1'b1; addr_b = AW'(1);
    cyc();
    chk("t1_clr_c1", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_read, mem_write, busy}), 32'd0);
    cyc();
    chk("t1_clr_c2", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_read, mem_write, busy}), 32'd0);
    chk("t1_clr_rdata", 32'({rdata_a, rdata_b}), 32'd0);
    clear = 1'b0;
    cyc();
    chk("t1_first_gnt", 32'({gnt_a, gnt_b}), 32'd2);
    chk("t1_busy_issue", 32'(busy), 32'd1);
    req_a = 1'b0;
    cyc();
    chk("t1_busy_capture", 32'(busy), 32'd1);
    cyc();
    chk("t1_rvalid_a", 32'(rvalid_a), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    cyc();
    chk("t1_gnt_b", 32'({gnt_a, gnt_b}), 32'd1);
    req_b = 1'b0;
    cyc();
    cyc();
    chk("t1_rvalid_b", 32'(rvalid_b), 32'd1);

    // A writes 3 = A5, then reads it back.
    req_a = 1'b1; we_a = 1'b1; addr_a = AW'(3); wdata_a = 8'hA5;
    cyc();
    chk("t2_gnt_a", 32'(gnt_a), 32'd1);
    chk("t2_mem_write", 32'({mem_write, mem_read}), 32'd2);
    chk("t2_mem_addr", 32'(mem_addr), 32'd3);
    chk("t2_mem_wdata", 32'(mem_wdata), 32'hA5);
    we_a = 1'b0;
    cyc();
    chk("t2_wr_idle", 32'({gnt_a, busy}), 32'd0);
    cyc();
    chk("t2_rd_gnt", 32'({gnt_a, mem_read}), 32'd3);
    req_a = 1'b0;
    cyc();
    chk("t2_no_rvalid_capture", 32'(rvalid_a), 32'd0);
    cyc();
    chk("t2_rvalid_a", 32'(rvalid_a), 32'd1);
    chk("t2_rdata_a", 32'(rdata_a), 32'hA5);

    // rr_ptr is B: B's write to 31 goes first, then A reads 3C.
    req_b = 1'b1; we_b = 1'b1; addr_b = AW'(31); wdata_b = 8'h3C;
    req_a = 1'b1; we_a = 1'b0; addr_a = AW'(31);
    cyc();
    chk("t4_gnt_b_first", 32'({gnt_a, gnt_b}), 32'd1);
    chk("t4_mem_addr", 32'(mem_addr), 32'd31);
    chk("t4_mem_wdata", 32'(mem_wdata), 32'h3C);
    req_b = 1'b0; we_b = 1'b0;
    cyc();
    chk("t4_idle", 32'(gnt_a), 32'd0);
    cyc();
    chk("t4_gnt_a", 32'({gnt_a, mem_read}), 32'd3);
    req_a = 1'b0;
    cyc();
    cyc();
    chk("t4_rvalid_a", 32'(rvalid_a), 32'd1);
    chk("t4_rdata_a", 32'(rdata_a), 32'h3C);

    // Both ports requesting continuously: grants alternate starting with B.
    req_a = 1'b1; we_a = 1'b0; addr_a = AW'(0);
    req_b = 1'b1; we_b = 1'b0; addr_b = AW'(1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t3_gnt_a", 32'(gnt_a), 32'(k % 2));
      chk("t3_gnt_b", 32'(gnt_b), 32'((k + 1) % 2));
      chk("t3_busy_issue", 32'(busy), 32'd1);
      cyc();
      chk("t3_busy_capture", 32'(busy), 32'd1);
      cyc();
      chk("t3_busy_idle", 32'(busy), 32'd0);
      chk("t3_rvalid", 32'({rvalid_a, rvalid_b}), (k % 2 == 1) ? 32'd2 : 32'd1);
    end
    req_a = 1'b0;
    req_b = 1'b0;

    // clear during CAPTURE of an A read abandons it.
    req_a = 1'b1; we_a = 1'b0; addr_a = AW'(3);
    cyc();
    chk("t5_gnt_a1", 32'(gnt_a), 32'd1);
    addr_a = AW'(31);
    cyc();
    cyc();
    chk("t5_rdata_a1", 32'({rvalid_a, rdata_a}), 32'h1A5);
    cyc();
    chk("t5_gnt_a2", 32'(gnt_a), 32'd1);
    req_a = 1'b0;
    cyc();
    chk("t5_capture_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    cyc();
    chk("t5_no_rvalid", 32'(rvalid_a), 32'd0);
    chk("t5_rdata_zero", 32'(rdata_a), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    clear = 1'b0;
    req_a = 1'b1; addr_a = AW'(0);
    req_b = 1'b1; addr_b = AW'(1);
    cyc();
    chk("t5_rr_reset_a", 32'({gnt_a, gnt_b}), 32'd2);
    req_a = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t5_gnt_b", 32'(gnt_b), 32'd1);
    req_b = 1'b0;
    cyc();
    cyc();

    // Random traffic with occasional withdrawals and resets.
    for (int c = 0; c < 10000; c++) begin
      cyc();
      if (clear) clear = 1'b0;
      else if ($urandom_range(0, 999) == 0) clear = 1'b1;
      if (req_a && gnt_a) req_a = 1'b0;
      else if (req_a && $urandom_range(0, 15) == 0) req_a = 1'b0;
      if (!req_a && $urandom_range(0, 2) == 0) begin
        req_a   = 1'b1;
        we_a    = 1'($urandom_range(0, 1));
        addr_a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
        wdata_a = DW'($urandom);
      end
      if (req_b && gnt_b) req_b = 1'b0;
      else if (req_b && $urandom_range(0, 15) == 0) req_b = 1'b0;
      if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b   = 1'b1;
        we_b    = 1'($urandom_range(0, 1));
        addr_b  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
        wdata_b = DW'($urandom);
      end
    end
    clear = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (6) cyc();
    chk("drain_qa", 32'(qa.size()), 32'd0);
    chk("drain_qb", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
